// File: rtl/delay_config_loader.sv
// delay_config_loader: UART framed config loader with a double-buffered delay table and a read port
module delay_config_loader #(
    parameter int         NUM_CH      = 8,
    parameter int         NUM_ALINES  = 16,
    parameter int         DELAY_BYTES = 2,
    parameter int         PULSE_BYTES = 4,
    parameter logic [2:0] HANDSHAKE   = 3'b110,
    parameter int         TIMEOUT     = 65535
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        uart_data,
    input  logic                              new_data,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [$clog2(NUM_ALINES)-1:0]     which_aline,
    output logic                              intaking_configs,
    output logic                              config_done,
    output logic                              config_error,
    output logic [NUM_CH-1:0]                 channel_select,
    output logic [7:0]                        aline_select,
    output logic [8*PULSE_BYTES-1:0]          pulse_shape,
    output logic                              updating_delays,
    output logic                              delays_valid,
    output logic [NUM_CH*8*DELAY_BYTES-1:0]   delays,
    output logic                              active_bank
);
    localparam int MASK_BYTES = (NUM_CH + 7) / 8;
    localparam int AW         = $clog2(NUM_ALINES);
    localparam int DELAY_W    = 8 * DELAY_BYTES;
    localparam int PULSE_W    = 8 * PULSE_BYTES;
    localparam int MW         = 8 * MASK_BYTES;
    localparam int CW         = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW         = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, MASK, ALINE, PULSE, DELAY, CHECK} lstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    lstate_t                    ls_q, ls_d;
    rstate_t                    rs_q, rs_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [AW-1:0]              aline_q, aline_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [7:0]                 csum_q, csum_d;
    logic [MW-1:0]              mask_sh_q, mask_sh_d;
    logic [7:0]                 al_sh_q, al_sh_d;
    logic [PULSE_W-1:0]         pulse_sh_q, pulse_sh_d;
    logic [DELAY_W-1:0]         dword_q, dword_d;
    logic [NUM_CH-1:0]          chsel_q, chsel_d;
    logic [7:0]                 alsel_q, alsel_d;
    logic [PULSE_W-1:0]         pulse_q, pulse_d;
    logic                       bank_q, bank_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [AW-1:0]              raddr_q, raddr_d;
    logic                       rbank_q, rbank_d;
    logic [NUM_CH*DELAY_W-1:0]  delays_q, delays_d;
    logic                       hdr_ok, word_last, aline_last, ch_last;
    logic                       timeout, check_hit, commit, mem_we;
    logic [DELAY_W-1:0]         mem_wdata;
    logic [DELAY_W-1:0]         mem [2][NUM_CH][NUM_ALINES];

    // Frame decode: field boundaries, checksum match, timeout and delay-word write strobe
    always_comb begin
        hdr_ok     = new_data && wr_en && uart_data[7:5] == HANDSHAKE;
        word_last  = cnt_q == 8'(DELAY_BYTES - 1);
        aline_last = aline_q == AW'(NUM_ALINES - 1);
        ch_last    = ch_q == CW'(NUM_CH - 1);
        timeout    = ls_q != IDLE && !new_data && tmo_q == TW'(TIMEOUT - 1);
        check_hit  = ls_q == CHECK && new_data;
        commit     = check_hit && uart_data == csum_q;
        mem_wdata  = DELAY_W'({dword_q, uart_data});
        mem_we     = ls_q == DELAY && new_data && word_last;
    end

    // Load FSM next state; a timeout aborts from any field
    always_comb begin
        ls_d = ls_q;
        case (ls_q)
            IDLE:    ls_d = hdr_ok ? MASK : IDLE;
            MASK:    ls_d = new_data && cnt_q == 8'(MASK_BYTES - 1) ? ALINE : MASK;
            ALINE:   ls_d = new_data ? PULSE : ALINE;
            PULSE:   ls_d = new_data && cnt_q == 8'(PULSE_BYTES - 1) ? DELAY : PULSE;
            DELAY:   ls_d = mem_we && aline_last && ch_last ? CHECK : DELAY;
            CHECK:   ls_d = new_data ? IDLE : CHECK;
            default: ls_d = IDLE;
        endcase
        if (timeout) ls_d = IDLE;
    end

    // Load datapath: counters, shadow fields, checksum and atomic commit of the outputs
    always_comb begin
        cnt_d   = cnt_q;
        aline_d = aline_q;
        ch_d    = ch_q;
        if (new_data && (ls_q == MASK || ls_q == PULSE || ls_q == DELAY)) cnt_d = cnt_q + 8'd1;
        if (mem_we) begin
            cnt_d   = '0;
            aline_d = aline_q + AW'(1);
            ch_d    = aline_last ? ch_q + CW'(1) : ch_q;
        end
        if (ls_d != ls_q) begin
            cnt_d   = '0;
            aline_d = '0;
            ch_d    = '0;
        end
        tmo_d      = (ls_q == IDLE || new_data) ? '0 : tmo_q + TW'(1);
        csum_d     = ls_q == IDLE ? 8'd0 : (new_data && ls_q != CHECK ? csum_q ^ uart_data : csum_q);
        mask_sh_d  = ls_q == MASK && new_data ? MW'({mask_sh_q, uart_data}) : mask_sh_q;
        al_sh_d    = ls_q == ALINE && new_data ? uart_data : al_sh_q;
        pulse_sh_d = ls_q == PULSE && new_data ? PULSE_W'({pulse_sh_q, uart_data}) : pulse_sh_q;
        dword_d    = ls_q == DELAY && new_data ? mem_wdata : dword_q;
        chsel_d    = commit ? mask_sh_q[NUM_CH-1:0] : chsel_q;
        alsel_d    = commit ? al_sh_q : alsel_q;
        pulse_d    = commit ? pulse_sh_q : pulse_q;
        bank_d     = bank_q ^ commit;
        done_d     = commit;
        err_d      = (check_hit && !commit) || timeout;
    end

    // Read FSM next state; requests outside R_IDLE are dropped
    always_comb begin
        rs_d = rs_q;
        case (rs_q)
            R_IDLE:  rs_d = rd_en ? R_ADDR : R_IDLE;
            R_ADDR:  rs_d = R_DATA;
            default: rs_d = R_IDLE;
        endcase
    end

    // Read datapath: latch address and the bank live at request time, gather all channels
    always_comb begin
        raddr_d  = rs_q == R_IDLE && rd_en ? which_aline : raddr_q;
        rbank_d  = rs_q == R_IDLE && rd_en ? bank_q : rbank_q;
        delays_d = delays_q;
        for (int c = 0; c < NUM_CH; c++)
            if (rs_q == R_ADDR) delays_d[c*DELAY_W +: DELAY_W] = mem[rbank_q][c][raddr_q];
    end

    // Output decode from state and registered results
    always_comb begin
        intaking_configs = ls_q != IDLE;
        updating_delays  = rs_q != R_IDLE;
        delays_valid     = rs_q == R_DATA;
        config_done      = done_q;
        config_error     = err_q;
        channel_select   = chsel_q;
        aline_select     = alsel_q;
        pulse_shape      = pulse_q;
        delays           = delays_q;
        active_bank      = bank_q;
    end

    // State registers for both FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_q <= IDLE;
            rs_q <= R_IDLE;
        end else begin
            ls_q <= ls_d;
            rs_q <= rs_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            aline_q    <= '0;
            ch_q       <= '0;
            tmo_q      <= '0;
            csum_q     <= '0;
            mask_sh_q  <= '0;
            al_sh_q    <= '0;
            pulse_sh_q <= '0;
            dword_q    <= '0;
            chsel_q    <= '0;
            alsel_q    <= '0;
            pulse_q    <= '0;
            bank_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            raddr_q    <= '0;
            rbank_q    <= 1'b0;
            delays_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            aline_q    <= aline_d;
            ch_q       <= ch_d;
            tmo_q      <= tmo_d;
            csum_q     <= csum_d;
            mask_sh_q  <= mask_sh_d;
            al_sh_q    <= al_sh_d;
            pulse_sh_q <= pulse_sh_d;
            dword_q    <= dword_d;
            chsel_q    <= chsel_d;
            alsel_q    <= alsel_d;
            pulse_q    <= pulse_d;
            bank_q     <= bank_d;
            done_q     <= done_d;
            err_q      <= err_d;
            raddr_q    <= raddr_d;
            rbank_q    <= rbank_d;
            delays_q   <= delays_d;
        end
    end

    // Delay table: loads always target the bank not serving reads; never cleared
    always_ff @(posedge clk) begin
        if (mem_we) mem[!bank_q][ch_q][aline_q] <= mem_wdata;
    end
endmodule
